// File: rtl/store_merge_unit.sv
// store_merge_unit
// Narrows CPU store data (sw/sh/sb) into a word-wide single-port data RAM.
// Full-word stores are written directly; halfword/byte stores read the
// target word, splice the new lane(s) in, and write the word back.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        store request, sampled only while ready=1
//   ready      unit idle, can accept req
//   StoreOp    00=sw, 01=sh, 10=sb, 11=reserved
//   addr       byte address, captured on accept
//   wdata      store data (sh uses [15:0], sb uses [7:0]), captured on accept
//   done       one-cycle pulse in the RAM write cycle
//   err        one-cycle pulse for misaligned/reserved requests (no RAM access)
//   mem_en     RAM enable
//   mem_we     RAM write enable
//   mem_addr   RAM word address (captured addr[ADDR_W+1:2])
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid one cycle after the read is issued
module store_merge_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    output logic              ready,
    input  logic [1:0]        StoreOp,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          op_reg;
    logic [ADDR_W+1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         merged_reg;
    logic [31:0]         merged_next;
    logic [3:0]          lane_hit;
    logic                bad_req;
    logic                accept;

    // Address bits above the RAM range are deliberately dropped (wrap).
    logic addr_unused;
    assign addr_unused = &{1'b0, addr[31:ADDR_W+2]};

    assign accept = (state_reg == IDLE) && req;

    // Alignment / opcode check on the live request, used only at accept.
    always_comb begin
        bad_req = 1'b0;
        case (StoreOp)
            OP_SW:   bad_req = (addr[1:0] != 2'b00);
            OP_SH:   bad_req = addr[0];
            OP_SB:   bad_req = 1'b0;
            default: bad_req = 1'b1;
        endcase
    end

    // Lane splice: each byte lane takes either the fresh store byte or the
    // byte read back from RAM. For sh the upper byte of the half comes from
    // wdata[15:8] (odd lanes), the lower from wdata[7:0] (even lanes).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = (op_reg == OP_SB) ?
                                  (addr_reg[1:0] == 2'(gi)) :
                                  (addr_reg[1] == ((gi / 2) == 1));
            assign merged_next[8*gi +: 8] =
                !lane_hit[gi]                          ? mem_rdata[8*gi +: 8] :
                ((op_reg == OP_SH) && ((gi % 2) == 1)) ? wdata_reg[15:8] :
                                                         wdata_reg[7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            op_reg     <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= 32'h0;
            merged_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= StoreOp;
                addr_reg  <= addr[ADDR_W+1:0];
                wdata_reg <= wdata;
            end
            if (state_reg == MRG) begin
                merged_reg <= merged_next;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (bad_req)               state_next = ERR;
                    else if (StoreOp == OP_SW) state_next = WR;
                    else                       state_next = RD;
                end
            end
            RD: begin
                mem_en     = 1'b1;
                mem_addr   = addr_reg[ADDR_W+1:2];
                state_next = MRG;
            end
            MRG: begin
                // RAM data for the RD cycle is on mem_rdata now.
                state_next = WR;
            end
            WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                done       = 1'b1;
                mem_addr   = addr_reg[ADDR_W+1:2];
                mem_wdata  = (op_reg == OP_SW) ? wdata_reg : merged_reg;
                state_next = IDLE;
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: a table of directed store
// vectors plus hand-written sequences for reset-in-flight and back-to-back.
module tb_store_merge_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset_n;
    logic              req;
    logic              ready;
    logic [1:0]        StoreOp;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              done;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .ready     (ready),
        .StoreOp   (StoreOp),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1-cycle synchronous read, bench-side preload port.
    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic preload(input int word, input logic [31:0] val);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(word);
        pl_data = val;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int          word;
        logic [31:0] pre;
        logic [31:0] exp_word;
        bit          is_err;
        int          lat;
    } vec_t;

    task automatic run_store(input vec_t v, input int idx);
        int cyc, got_lat, n_rd, n_wr, first_we;
        bit seen_err, both, bad_addr;
        string tag;
        tag = $sformatf("v%0d", idx);
        got_lat = 0; n_rd = 0; n_wr = 0; first_we = -1;
        seen_err = 0; both = 0; bad_addr = 0;
        @(negedge clk);
        chk({tag, " ready_before"}, 32'(ready), 32'd1);
        req = 1'b1; StoreOp = v.op; addr = v.a; wdata = v.d;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; they must have no effect.
        req = 1'b0; StoreOp = ~v.op; addr = ~v.a; wdata = ~v.d;
        cyc = 1;
        while (got_lat == 0 && cyc <= 8) begin
            if (mem_en) begin
                if (first_we < 0) first_we = int'(mem_we);
                if (mem_we) n_wr++; else n_rd++;
                if (int'(mem_addr) != v.word) bad_addr = 1;
            end
            if (done && err) both = 1;
            if (done || err) begin
                got_lat  = cyc;
                seen_err = err;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " latency"}, 32'(got_lat), 32'(v.lat));
        chk({tag, " err_vs_done"}, 32'(seen_err), 32'(v.is_err));
        chk({tag, " done_and_err"}, 32'(both), 32'd0);
        chk({tag, " reads"}, 32'(n_rd), (v.is_err || v.op == 2'b00) ? 32'd0 : 32'd1);
        chk({tag, " writes"}, 32'(n_wr), v.is_err ? 32'd0 : 32'd1);
        chk({tag, " mem_addr"}, 32'(bad_addr), 32'd0);
        if (!v.is_err)
            chk({tag, " first_access_we"}, 32'(first_we), (v.op == 2'b00) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({tag, " pulse_one_cycle"}, {30'd0, done, err}, 32'd0);
        chk({tag, " ready_after"}, 32'(ready), 32'd1);
        chk({tag, " ram_word"}, ram[v.word], v.exp_word);
        $display("%s op=%0b addr=0x%08h wdata=0x%08h lat=%0d err=%0b ram[0x%0h]=0x%08h",
                 tag, v.op, v.a, v.d, got_lat, seen_err, v.word, ram[v.word]);
    endtask

    vec_t vecs [12];

    initial begin
        int k, last, cyc;
        vecs[0]  = '{2'b10, 32'h0000_0102, 32'h0000_00AB, 'h40, 32'h1122_3344, 32'h11AB_3344, 1'b0, 3};
        vecs[1]  = '{2'b01, 32'h0000_0102, 32'h1234_BEEF, 'h40, 32'h1122_3344, 32'hBEEF_3344, 1'b0, 3};
        vecs[2]  = '{2'b01, 32'h0000_0100, 32'h1234_BEEF, 'h40, 32'h1122_3344, 32'h1122_BEEF, 1'b0, 3};
        vecs[3]  = '{2'b00, 32'h0000_0104, 32'hDEAD_BEEF, 'h41, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[4]  = '{2'b01, 32'h0000_0101, 32'h0000_5555, 'h40, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};
        vecs[5]  = '{2'b00, 32'h0000_0106, 32'h5555_5555, 'h41, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};
        vecs[6]  = '{2'b11, 32'h0000_0100, 32'h5555_5555, 'h40, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};
        vecs[7]  = '{2'b10, 32'h0000_0100, 32'h9999_9955, 'h40, 32'h1122_3344, 32'h1122_3355, 1'b0, 3};
        vecs[8]  = '{2'b10, 32'h0000_0103, 32'hFFFF_FF77, 'h40, 32'h1122_3344, 32'h7722_3344, 1'b0, 3};
        vecs[9]  = '{2'b00, 32'hFFFF_F104, 32'hCAFE_F00D, 'h41, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1};
        vecs[10] = '{2'b10, 32'h0000_0101, 32'h0000_00CD, 'h40, 32'h1122_3344, 32'h1122_CD44, 1'b0, 3};
        vecs[11] = '{2'b01, 32'hABCD_E102, 32'h0000_C0DE, 'h40, 32'h1122_3344, 32'hC0DE_3344, 1'b0, 3};

        reset_n = 1'b0; req = 1'b0; StoreOp = 2'b00; addr = 32'h0; wdata = 32'h0;
        pl_en = 1'b0; pl_addr = '0; pl_data = 32'h0;
        #3;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_outs", {27'd0, done, err, mem_en, mem_we, 1'b0}, 32'd0);
        chk("reset_addr_data", 32'(mem_addr) | mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            preload(vecs[i].word, vecs[i].pre);
            run_store(vecs[i], i);
        end

        // Reset asserted during MRG: RAM untouched, outputs idle at once.
        preload('h40, 32'h1122_3344);
        @(negedge clk);
        req = 1'b1; StoreOp = 2'b10; addr = 32'h103; wdata = 32'hFF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("rst_seq rd_cycle", {29'd0, mem_en, mem_we, 1'b0}, 32'h4);
        chk("rst_seq rd_addr", 32'(mem_addr), 32'h40);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_seq ready", 32'(ready), 32'd1);
        chk("rst_seq outs", {28'd0, done, err, mem_en, mem_we}, 32'd0);
        chk("rst_seq addr_data", 32'(mem_addr) | mem_wdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_seq ram_unchanged", ram['h40], 32'h1122_3344);
        $display("rst_seq ram[0x40]=0x%08h", ram['h40]);
        run_store('{2'b00, 32'h0000_0100, 32'h0BAD_F00D, 'h40, 32'h1122_3344, 32'h0BAD_F00D, 1'b0, 1}, 100);

        // Back-to-back byte stores with req held high.
        preload('h40, 32'h0);
        @(negedge clk);
        req = 1'b1; StoreOp = 2'b10; addr = 32'h100; wdata = 32'hA0;
        k = 0; last = 0; cyc = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (k > 0) chk($sformatf("b2b interval%0d", k), 32'(cyc - last), 32'd4);
                $display("b2b done%0d at cycle %0d", k, cyc);
                last = cyc;
                k++;
                if (k < 4) begin
                    addr  = 32'h100 + 32'(k);
                    wdata = 32'hA0 + 32'(k);
                end else begin
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        chk("b2b done_count", 32'(k), 32'd4);
        @(negedge clk);
        chk("b2b ram_word", ram['h40], 32'hA3A2_A1A0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
